// File: rtl/rx_deser_pkg.sv
// Shared types and constants for the RX deserialiser.
// Optional parity support is enabled with RX_DESER_PARITY_EN.
package rx_deser_pkg;

  localparam int DATA_W_MIN = 5;
  localparam int DATA_W_MAX = 9;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

`ifdef RX_DESER_PARITY_EN
  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD,
    PARITY
  } rx_state_e;
`else
  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD
  } rx_state_e;
`endif

endpackage

// File: rtl/rx_deserialiser_parity.sv
// Parity checker for a received word plus its parity bit.
// Only instantiated when RX_DESER_PARITY_EN is defined.
module rx_parity_chk
  import rx_deser_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic              par_typ_i,
  input  logic              par_bit_i,
  output logic              err_o
);

  logic exp_bit;

  assign exp_bit = (par_typ_i == PAR_ODD) ? ~^data_i : ^data_i;
  assign err_o   = (exp_bit != par_bit_i);

endmodule

// File: rtl/rx_deserialiser.sv
// Serial-to-parallel frame receiver sampled on qualified bit ticks.
// Define RX_DESER_PARITY_EN to add a trailing parity bit and PAR_ERR.
module rx_deserialiser
  import rx_deser_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              SER_DATA,
  input  logic              EN,
  input  logic              RX_tick,
  input  logic              TICK_EN,
`ifdef RX_DESER_PARITY_EN
  input  logic              PAR_TYP,
  output logic              PAR_ERR,
`endif
  output logic [DATA_W-1:0] PARALLEL_DATA,
  output logic              DESER_DONE,
  output logic              DATA_VALID,
  output logic [3:0]        BIT_CNT
);

  localparam logic [3:0] CNT_MAX = 4'(DATA_W);

  rx_state_e         state_q, state_d;
  logic [DATA_W-1:0] sh_q, sh_d, sh_nxt;
  logic [DATA_W-1:0] word_q, word_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              valid_q, valid_d;
  logic              qtick;

  assign qtick = EN & TICK_EN & RX_tick;

  always_comb begin
    if (MSB_FIRST) sh_nxt = {sh_q[DATA_W-2:0], SER_DATA};
    else           sh_nxt = {SER_DATA, sh_q[DATA_W-1:1]};
  end

`ifdef RX_DESER_PARITY_EN
  logic perr_q, perr_d, perr_calc;

  rx_parity_chk #(
    .DATA_W(DATA_W)
  ) u_par (
    .data_i   (sh_q),
    .par_typ_i(PAR_TYP),
    .par_bit_i(SER_DATA),
    .err_o    (perr_calc)
  );

  assign PAR_ERR = perr_q;
`endif

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    valid_d = 1'b0;
`ifdef RX_DESER_PARITY_EN
    perr_d  = perr_q;
`endif
    if (!EN) begin
      state_d = IDLE;
      sh_d    = '0;
      cnt_d   = '0;
      done_d  = 1'b0;
`ifdef RX_DESER_PARITY_EN
      perr_d  = 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          // Arming cycle: a tick coinciding with EN rising is not sampled
          state_d = SHIFT;
          cnt_d   = '0;
        end
        SHIFT: begin
          if (qtick) begin
            sh_d  = sh_nxt;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == CNT_MAX - 4'd1) begin
`ifdef RX_DESER_PARITY_EN
              state_d = PARITY;
`else
              state_d = HOLD;
              word_d  = sh_nxt;
              done_d  = 1'b1;
              valid_d = 1'b1;
`endif
            end
          end
        end
`ifdef RX_DESER_PARITY_EN
        PARITY: begin
          if (qtick) begin
            state_d = HOLD;
            word_d  = sh_q;
            done_d  = 1'b1;
            valid_d = 1'b1;
            perr_d  = perr_calc;
          end
        end
`endif
        HOLD: begin
          state_d = HOLD;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      sh_q    <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      valid_q <= valid_d;
    end
  end

`ifdef RX_DESER_PARITY_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) perr_q <= 1'b0;
    else      perr_q <= perr_d;
  end
`endif

  assign PARALLEL_DATA = word_q;
  assign DESER_DONE    = done_q;
  assign DATA_VALID    = valid_q;
  assign BIT_CNT       = cnt_q;

endmodule

// File: tb/tb_rx_deserialiser.sv
// Self-checking bench for rx_deserialiser (LSB-first and MSB-first instances).
// Parity checks are active when RX_DESER_PARITY_EN is defined.
module tb_rx_deserialiser;

  localparam int W = 8;
`ifdef RX_DESER_PARITY_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic SER_DATA = 1'b0;
  logic EN = 1'b0;
  logic RX_tick = 1'b0;
  logic TICK_EN = 1'b0;
  logic [W-1:0] d_l, d_m;
  logic done_l, done_m, val_l, val_m;
  logic [3:0] cnt_l, cnt_m;
`ifdef RX_DESER_PARITY_EN
  logic PAR_TYP = 1'b0;
  logic perr_l, perr_m;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  rx_deserialiser #(.DATA_W(W), .MSB_FIRST(1'b0)) u_lsb (
    .CLK(CLK), .RST(RST), .SER_DATA(SER_DATA), .EN(EN),
    .RX_tick(RX_tick), .TICK_EN(TICK_EN),
`ifdef RX_DESER_PARITY_EN
    .PAR_TYP(PAR_TYP), .PAR_ERR(perr_l),
`endif
    .PARALLEL_DATA(d_l), .DESER_DONE(done_l),
    .DATA_VALID(val_l), .BIT_CNT(cnt_l)
  );

  rx_deserialiser #(.DATA_W(W), .MSB_FIRST(1'b1)) u_msb (
    .CLK(CLK), .RST(RST), .SER_DATA(SER_DATA), .EN(EN),
    .RX_tick(RX_tick), .TICK_EN(TICK_EN),
`ifdef RX_DESER_PARITY_EN
    .PAR_TYP(PAR_TYP), .PAR_ERR(perr_m),
`endif
    .PARALLEL_DATA(d_m), .DESER_DONE(done_m),
    .DATA_VALID(val_m), .BIT_CNT(cnt_m)
  );

  // Reference model: bits of the current frame kept in a queue
  bit         m_armed;
  bit         m_bits[$];
  logic [W-1:0] m_wl, m_wm;
  bit         m_done, m_valid, m_perr;

  task automatic m_reset();
    m_armed = 0;
    m_bits.delete();
    m_wl = '0;
    m_wm = '0;
    m_done = 0;
    m_valid = 0;
    m_perr = 0;
  endtask

  task automatic m_edge();
    bit qt;
    qt = EN && TICK_EN && RX_tick;
    m_valid = 0;
    if (!EN) begin
      m_armed = 0;
      m_bits.delete();
      m_done = 0;
      m_perr = 0;
    end else if (!m_armed) begin
      m_armed = 1;
    end else if (qt && m_bits.size() < FRAME) begin
      m_bits.push_back(SER_DATA);
      if (m_bits.size() == FRAME) begin
        for (int i = 0; i < W; i++) begin
          m_wl[i] = m_bits[i];
          m_wm[W-1-i] = m_bits[i];
        end
        m_done = 1;
        m_valid = 1;
`ifdef RX_DESER_PARITY_EN
        m_perr = ((^m_wl) ^ PAR_TYP) != m_bits[W];
`endif
      end
    end
  endtask

  function automatic int m_cnt();
    return (m_bits.size() > W) ? W : m_bits.size();
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    chk("lsb_data", 32'(d_l), 32'(m_wl));
    chk("msb_data", 32'(d_m), 32'(m_wm));
    chk("lsb_done", 32'(done_l), 32'(m_done));
    chk("msb_done", 32'(done_m), 32'(m_done));
    chk("lsb_valid", 32'(val_l), 32'(m_valid));
    chk("msb_valid", 32'(val_m), 32'(m_valid));
    chk("lsb_cnt", 32'(cnt_l), 32'(m_cnt()));
    chk("msb_cnt", 32'(cnt_m), 32'(m_cnt()));
`ifdef RX_DESER_PARITY_EN
    chk("lsb_perr", 32'(perr_l), 32'(m_perr));
    chk("msb_perr", 32'(perr_m), 32'(m_perr));
`endif
  endtask

  task automatic step(input bit en, input bit tick, input bit ten,
                      input bit ser);
    EN = en;
    RX_tick = tick;
    TICK_EN = ten;
    SER_DATA = ser;
    m_edge();
    @(posedge CLK);
    #1;
    cmp_model();
  endtask

  task automatic rst_mid();
    #3;
    RST = 1'b0;
    #1;
    chk("arst_data", 32'(d_l), 32'h0);
    chk("arst_done", 32'(done_l), 32'h0);
    chk("arst_valid", 32'(val_l), 32'h0);
    chk("arst_cnt", 32'(cnt_l), 32'h0);
    chk("arst_msb_data", 32'(d_m), 32'h0);
    m_reset();
    EN = 1'b0;
    RX_tick = 1'b0;
    @(posedge CLK);
    #3;
    RST = 1'b1;
  endtask

  typedef struct {
    bit         en, tick, ten, ser;
    logic [7:0] data;
    bit         done, valid;
    logic [3:0] cnt;
  } vec_t;

  vec_t tbl[$];
  bit   seq4d[8];
  bit   seqa5[8];

  initial begin
    seq4d = '{1, 0, 1, 1, 0, 0, 1, 0};
    seqa5 = '{1, 0, 1, 0, 0, 1, 0, 1};
    m_reset();

    // Directed frame 8'h4D with ignored ticks around it
    tbl.push_back('{1, 1, 1, 1, 8'h00, 0, 0, 4'd0});
    for (int i = 0; i < 8; i++) begin
      bit last;
      last = (i == 7) && (FRAME == W);
      tbl.push_back('{1, 1, 1, seq4d[i], last ? 8'h4D : 8'h00,
                      last, last, 4'(i + 1)});
      if (i == 3)
        tbl.push_back('{1, 1, 0, 1, 8'h00, 0, 0, 4'd4});
    end
`ifdef RX_DESER_PARITY_EN
    tbl.push_back('{1, 1, 1, 0, 8'h4D, 1, 1, 4'd8});
`endif
    tbl.push_back('{1, 1, 1, 1, 8'h4D, 1, 0, 4'd8});
    tbl.push_back('{1, 1, 1, 0, 8'h4D, 1, 0, 4'd8});
    tbl.push_back('{0, 1, 1, 1, 8'h4D, 0, 0, 4'd0});

    #12;
    chk("rst_data", 32'(d_l), 32'h0);
    chk("rst_done", 32'(done_l), 32'h0);
    chk("rst_valid", 32'(val_l), 32'h0);
    chk("rst_cnt", 32'(cnt_l), 32'h0);
    #1;
    RST = 1'b1;

    foreach (tbl[k]) begin
      step(tbl[k].en, tbl[k].tick, tbl[k].ten, tbl[k].ser);
      chk("tbl_data", 32'(d_l), 32'(tbl[k].data));
      chk("tbl_done", 32'(done_l), 32'(tbl[k].done));
      chk("tbl_valid", 32'(val_l), 32'(tbl[k].valid));
      chk("tbl_cnt", 32'(cnt_l), 32'(tbl[k].cnt));
    end
    chk("msb_word_b2", 32'(d_m), 32'hB2);
`ifdef RX_DESER_PARITY_EN
    chk("par_ok", 32'(perr_l), 32'h0);
`endif

    // Abort after 4 bits, then an all-ones frame with gated ticks
    step(1, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 1, 1);
    chk("abort_cnt4", 32'(cnt_l), 32'd4);
    step(0, 1, 1, 1);
    chk("abort_valid", 32'(val_l), 32'h0);
    chk("abort_keep", 32'(d_l), 32'h4D);
    chk("abort_cnt", 32'(cnt_l), 32'h0);
    step(1, 1, 1, 1);
    for (int i = 0; i < 8; i++) begin
      step(1, 1, 0, 0);
      step(1, 1, 1, 1);
      if (i == 6) chk("ones_keep", 32'(d_l), 32'h4D);
    end
`ifdef RX_DESER_PARITY_EN
    step(1, 1, 1, 0);
`endif
    chk("ones_lsb", 32'(d_l), 32'hFF);
    chk("ones_msb", 32'(d_m), 32'hFF);
    chk("ones_valid", 32'(val_l), 32'h1);
    step(0, 0, 0, 0);

`ifdef RX_DESER_PARITY_EN
    // 8'h4D followed by a wrong even-parity bit
    step(1, 0, 1, 0);
    for (int i = 0; i < 8; i++) step(1, 1, 1, seq4d[i]);
    step(1, 1, 1, 1);
    chk("par_bad", 32'(perr_l), 32'h1);
    step(1, 0, 0, 0);
    chk("par_hold", 32'(perr_l), 32'h1);
    step(0, 0, 0, 0);
    chk("par_clr", 32'(perr_l), 32'h0);
`endif

    // Asynchronous reset mid-frame, then 8'hA5
    step(1, 0, 1, 0);
    for (int i = 0; i < 5; i++) step(1, 1, 1, 1);
    rst_mid();
    step(1, 1, 1, 1);
    chk("post_rst_cnt", 32'(cnt_l), 32'h0);
    for (int i = 0; i < 8; i++) step(1, 1, 1, seqa5[i]);
`ifdef RX_DESER_PARITY_EN
    step(1, 1, 1, 0);
`endif
    chk("a5_lsb", 32'(d_l), 32'hA5);
    chk("a5_msb", 32'(d_m), 32'hA5);
    chk("a5_valid", 32'(val_l), 32'h1);
    step(0, 0, 0, 0);

    // Randomised traffic against the reference model
    for (int n = 0; n < 1500; n++) begin
`ifdef RX_DESER_PARITY_EN
      if ($urandom_range(0, 15) == 0) PAR_TYP = 1'($urandom);
`endif
      step($urandom_range(0, 29) != 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 3) != 0, 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/rx_deserialiser.md
RX_DESERIALISER -- requirements
Module: rx_deserialiser

Interface
REQ-001 SHALL have parameter DATA_W, default 8, number of data bits per frame; legal range 5..9.
REQ-002 SHALL have parameter MSB_FIRST, default 0: 0 = first received bit is data bit 0; 1 = first received bit is bit DATA_W-1.
REQ-003 SHALL use one clock and an asynchronous, active-low reset: CLK  in  1  clock; RST  in  1  async active-low reset.
REQ-004 SHALL have SER_DATA  in  1  serial input bit, sampled only on qualified ticks.
REQ-005 SHALL have EN  in  1  frame enable; low = idle/abort.
REQ-006 SHALL have RX_tick  in  1  bit-centre sample strobe.
REQ-007 SHALL have TICK_EN  in  1  tick gate.
REQ-008 SHALL have PARALLEL_DATA  out  DATA_W  last completed word.
REQ-009 SHALL have DESER_DONE  out  1  frame complete, sticky until EN low.
REQ-010 SHALL have DATA_VALID  out  1  one-cycle pulse on frame completion.
REQ-011 SHALL have BIT_CNT  out  4  number of bits captured in the current frame.

Function
REQ-012 SHALL treat a cycle as a qualified tick iff EN && TICK_EN && RX_tick; all other cycles SHALL not sample.
REQ-013 SHALL implement states IDLE, SHIFT, HOLD; with the macro defined, also PARITY.
REQ-014 IDLE SHALL move to SHIFT when EN=1, with BIT_CNT=0.
REQ-015 In SHIFT, each qualified tick SHALL load SER_DATA into an internal shift register and increment BIT_CNT.
REQ-016 Shift direction: MSB_FIRST=0 shifts right, inserting at bit DATA_W-1; MSB_FIRST=1 shifts left, inserting at bit 0.
REQ-017 On the DATA_W-th qualified tick, the same clock edge SHALL copy the completed word to PARALLEL_DATA, set DESER_DONE=1, pulse DATA_VALID high for exactly one cycle, and enter HOLD (or PARITY).
REQ-018 PARALLEL_DATA SHALL change only at frame completion and SHALL hold its value through aborts and later frames until the next completion.
REQ-019 HOLD SHALL ignore ticks and keep DESER_DONE=1 until EN=0.
REQ-020 EN=0 in any state SHALL, on the next edge, enter IDLE, clear BIT_CNT, clear DESER_DONE, clear the shift register and discard any partial frame, with no DATA_VALID.
REQ-021 EN rising in the same cycle as a qualified tick SHALL not sample; the first sample is the next qualified tick.
REQ-022 BIT_CNT SHALL saturate at DATA_W and never wrap.

Reset
REQ-023 RST=0 SHALL asynchronously force IDLE, PARALLEL_DATA=0, DESER_DONE=0, DATA_VALID=0, BIT_CNT=0, shift register=0, and PAR_ERR=0 (when present).
REQ-024 Reset mid-frame SHALL discard the partial frame; the first frame after release SHALL begin from BIT_CNT=0.

Configuration
REQ-025 Macro RX_DESER_PARITY_EN, when defined, SHALL add ports PAR_TYP (in 1, 0 = even, 1 = odd) and PAR_ERR (out 1), and the state PARITY.
REQ-026 With RX_DESER_PARITY_EN defined, the tick after the last data bit SHALL be the parity bit.
REQ-027 With RX_DESER_PARITY_EN defined, completion actions (REQ-017) SHALL occur on the parity tick, not on the DATA_W-th tick.
REQ-028 With RX_DESER_PARITY_EN defined, PAR_ERR SHALL be set with DATA_VALID when the received parity mismatches the parity of the word under PAR_TYP, and SHALL hold until the next completion, EN=0, or reset.
REQ-029 Without RX_DESER_PARITY_EN, the PAR_TYP and PAR_ERR ports and the PARITY state SHALL not exist, and behaviour SHALL be as in REQ-012..022.

Structure
REQ-030 Package rx_deser_pkg SHALL hold the state enum, the DATA_W_MIN=5 and DATA_W_MAX=9 constants, and the PAR_EVEN/PAR_ODD constants.
REQ-031 Parity computation SHALL be the sub-module rx_parity_chk, instantiated only under RX_DESER_PARITY_EN.

Verification
REQ-032 DATA_W=8, MSB_FIRST=0, bits 1,0,1,1,0,0,1,0 on qualified ticks -> PARALLEL_DATA=8'h4D, DATA_VALID one cycle, DESER_DONE held until EN=0.
REQ-033 MSB_FIRST=1, same bit sequence -> PARALLEL_DATA=8'hB2.
REQ-034 EN dropped after 4 ticks, then a full frame of all 1s -> no DATA_VALID during the abort; final PARALLEL_DATA=8'hFF; the prior word is retained until then.
REQ-035 RX_tick pulses with TICK_EN=0 interleaved, and extra ticks while in HOLD -> ignored; BIT_CNT, PARALLEL_DATA and DATA_VALID unchanged by them.
REQ-036 Parity build, PAR_TYP=0, data 8'h4D: parity bit 0 -> PAR_ERR=0; parity bit 1 -> PAR_ERR=1.
REQ-037 RST asserted after 5 bits of a frame -> all outputs 0 immediately; the next full frame 8'hA5 is received correctly.
